// File: rtl/song_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : song_if                                                        |
// | Purpose   : Command, ROM and tone-generator signal bundle for the song     |
// |             sequencer.                                                     |
// |   master  : drives user commands, tempo_sel and rom_data (ROM side);       |
// |             observes rom_en/rom_addr, tone_div/tone_en, note_idx,          |
// |             busy and done.                                                 |
// |   slave   : the sequencer; the reverse directions.                         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface song_if #(
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 14
) ();
  logic              cmd_play;
  logic              cmd_pause;
  logic              cmd_stop;
  logic              cmd_next;
  logic [1:0]        tempo_sel;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DIV_W:0]    rom_data;
  logic [DIV_W-1:0]  tone_div;
  logic              tone_en;
  logic [ADDR_W-1:0] note_idx;
  logic              busy;
  logic              done;

  modport master (
    output cmd_play, cmd_pause, cmd_stop, cmd_next, tempo_sel, rom_data,
    input  rom_en, rom_addr, tone_div, tone_en, note_idx, busy, done
  );

  modport slave (
    input  cmd_play, cmd_pause, cmd_stop, cmd_next, tempo_sel, rom_data,
    output rom_en, rom_addr, tone_div, tone_en, note_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : song_sequencer                                                  |
// | Purpose  : Song playback controller. Steps a note index through the note   |
// |            ROM, latches each {divider, rest} word, times every note        |
// |            against a tempo-scaled beat and gates the tone with an          |
// |            articulation gap. Handles play/pause/stop/next commands.        |
// | Ports    : clk, rst (sync, active-high)                                    |
// |            bus (song_if.slave): cmd_play/pause/stop/next, tempo_sel,       |
// |            rom_en/rom_addr/rom_data, tone_div/tone_en, note_idx,           |
// |            busy, done                                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module song_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BEAT_HZ = 3,
  parameter int ADDR_W  = 10,
  parameter int LENGTH  = 783,
  parameter int DIV_W   = 14,
  parameter int GAP_CYC = CLK_HZ / BEAT_HZ / 16,
  parameter int LOOP    = 0
) (
  input  logic   clk,
  input  logic   rst,
  song_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_PAUSED = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [31:0]       c_beat_cyc = 32'(CLK_HZ / BEAT_HZ);
  localparam logic [31:0]       c_gap_cyc  = 32'(GAP_CYC);
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(LENGTH - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_note_idx;
  logic [DIV_W-1:0]  r_tone_div;
  logic              r_rest;
  logic [31:0]       r_beat_cnt;

  logic [31:0]       w_beat_len;
  logic              w_do_stop;
  logic              w_do_next;
  logic              w_do_pause;
  logic              w_do_play;
  logic              w_note_end;
  logic              w_last_note;

  // Only the highest-priority pulse of a cycle survives; the rest are dropped
  // even when the surviving one has no effect in the current state.
  assign w_do_stop  = bus.cmd_stop;
  assign w_do_next  = ~bus.cmd_stop & bus.cmd_next;
  assign w_do_pause = ~bus.cmd_stop & ~bus.cmd_next & bus.cmd_pause;
  assign w_do_play  = ~bus.cmd_stop & ~bus.cmd_next & ~bus.cmd_pause & bus.cmd_play;

  always_comb begin
    w_beat_len = c_beat_cyc;
    case (bus.tempo_sel)
      2'b01:   w_beat_len = c_beat_cyc >> 1;
      2'b10:   w_beat_len = c_beat_cyc << 1;
      default: w_beat_len = c_beat_cyc;
    endcase
  end

  // A note ends on skip or on beat expiry; a pause arriving on the expiry
  // cycle wins, so the note resumes at beat_cnt==0 and ends right after.
  assign w_note_end  = (r_state == S_PLAY) &
                       (w_do_next | (~w_do_pause & (r_beat_cnt == 32'd0)));
  assign w_last_note = (r_note_idx == c_last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_note_idx <= '0;
      r_tone_div <= '0;
      r_rest     <= 1'b0;
      r_beat_cnt <= '0;
    end else if (w_do_stop) begin
      // tone_div intentionally keeps its last value
      r_state    <= S_IDLE;
      r_note_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_do_play) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_tone_div <= bus.rom_data[DIV_W:1];
          r_rest     <= bus.rom_data[0];
          r_beat_cnt <= w_beat_len - 32'd1;
          r_state    <= S_PLAY;
        end
        S_PLAY: begin
          if (w_note_end) begin
            if (w_last_note) begin
              if (LOOP != 0) begin
                r_note_idx <= '0;
                r_state    <= S_FETCH;
              end else begin
                r_state    <= S_DONE;
              end
            end else begin
              r_note_idx <= r_note_idx + 1'b1;
              r_state    <= S_FETCH;
            end
          end else if (w_do_pause) begin
            r_state <= S_PAUSED;
          end else begin
            r_beat_cnt <= r_beat_cnt - 32'd1;
          end
        end
        S_PAUSED: begin
          if (w_do_play) r_state <= S_PLAY;
        end
        S_DONE: begin
          if (w_do_play) begin
            r_note_idx <= '0;
            r_state    <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rom_en   = (r_state == S_FETCH);
  assign bus.rom_addr = r_note_idx;
  assign bus.note_idx = r_note_idx;
  assign bus.tone_div = r_tone_div;
  // The last GAP_CYC cycles of each note are silent for articulation.
  assign bus.tone_en  = (r_state == S_PLAY) & ~r_rest & (r_beat_cnt >= c_gap_cyc);
  assign bus.busy     = (r_state == S_FETCH) | (r_state == S_LOAD) |
                        (r_state == S_PLAY)  | (r_state == S_PAUSED);
  assign bus.done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_song_sequencer                                               |
// | Purpose  : Self-checking bench for song_sequencer. Two instances (LOOP=0   |
// |            and LOOP=1) share one command stream; an elapsed-time note      |
// |            model predicts every output each cycle, and literal timing      |
// |            expectations pin the model.                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_song_sequencer;

  localparam int GAP  = 2;
  localparam int LEN  = 4;
  localparam int HMAX = 512;

  logic clk;
  logic rst;
  logic cmd_play, cmd_pause, cmd_stop, cmd_next;
  logic [1:0] tempo_sel;

  song_if #(.ADDR_W(10), .DIV_W(14)) bus0 ();
  song_if #(.ADDR_W(10), .DIV_W(14)) bus1 ();

  assign bus0.cmd_play  = cmd_play;
  assign bus0.cmd_pause = cmd_pause;
  assign bus0.cmd_stop  = cmd_stop;
  assign bus0.cmd_next  = cmd_next;
  assign bus0.tempo_sel = tempo_sel;
  assign bus1.cmd_play  = cmd_play;
  assign bus1.cmd_pause = cmd_pause;
  assign bus1.cmd_stop  = cmd_stop;
  assign bus1.cmd_next  = cmd_next;
  assign bus1.tempo_sel = tempo_sel;

  song_sequencer #(.CLK_HZ(100), .BEAT_HZ(10), .ADDR_W(10), .LENGTH(LEN),
                   .DIV_W(14), .GAP_CYC(GAP), .LOOP(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  song_sequencer #(.CLK_HZ(100), .BEAT_HZ(10), .ADDR_W(10), .LENGTH(LEN),
                   .DIV_W(14), .GAP_CYC(GAP), .LOOP(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM: divs 10,20,30,40; note 2 is a rest. Registered read.
  function automatic logic [14:0] rom_word(input int a);
    logic [13:0] d;
    d = 14'((a + 1) * 10);
    return {d, (a == 2)};
  endfunction

  always @(posedge clk) begin
    if (bus0.rom_en) bus0.rom_data <= rom_word(int'(bus0.rom_addr));
    if (bus1.rom_en) bus1.rom_data <= rom_word(int'(bus1.rom_addr));
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each note is tracked by elapsed cycles since its fetch: pos 0 = ROM read,
  // pos 1 = word arrives, pos >= 2 = sounding, lasting len cycles.
  int m_run[2], m_pause[2], m_fin[2], m_idx[2], m_pos[2], m_len[2], m_div[2], m_rest[2];
  int cyc = 0;

  function automatic int tempo_len(input logic [1:0] s);
    case (s)
      2'b01:   return 5;
      2'b10:   return 20;
      default: return 10;
    endcase
  endfunction

  task automatic end_note(input int l);
    if (m_idx[l] == LEN - 1) begin
      if (l == 1) begin m_idx[l] = 0; m_pos[l] = 0; end
      else begin m_run[l] = 0; m_fin[l] = 1; end
    end else begin
      m_idx[l]++;
      m_pos[l] = 0;
    end
  endtask

  task automatic model_step();
    int c;
    c = cmd_stop ? 4 : cmd_next ? 3 : cmd_pause ? 2 : cmd_play ? 1 : 0;
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        m_run[l] = 0; m_pause[l] = 0; m_fin[l] = 0; m_idx[l] = 0;
        m_pos[l] = 0; m_len[l] = 0; m_div[l] = 0; m_rest[l] = 0;
      end else if (c == 4) begin
        m_run[l] = 0; m_pause[l] = 0; m_fin[l] = 0; m_idx[l] = 0;
      end else if (m_fin[l] != 0) begin
        if (c == 1) begin m_fin[l] = 0; m_run[l] = 1; m_idx[l] = 0; m_pos[l] = 0; end
      end else if (m_run[l] == 0) begin
        if (c == 1) begin m_run[l] = 1; m_pos[l] = 0; end
      end else if (m_pause[l] != 0) begin
        if (c == 1) m_pause[l] = 0;
      end else if (m_pos[l] == 0) begin
        m_pos[l] = 1;
      end else if (m_pos[l] == 1) begin
        m_div[l]  = (m_idx[l] + 1) * 10;
        m_rest[l] = (m_idx[l] == 2) ? 1 : 0;
        m_len[l]  = tempo_len(tempo_sel);
        m_pos[l]  = 2;
      end else if (c == 3 || (c != 2 && (m_pos[l] - 2) == m_len[l] - 1)) begin
        end_note(l);
      end else if (c == 2) begin
        m_pause[l] = 1;
      end else begin
        m_pos[l]++;
      end
    end
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      m_run[l] = 0; m_pause[l] = 0; m_fin[l] = 0; m_idx[l] = 0;
      m_pos[l] = 0; m_len[l] = 0; m_div[l] = 0; m_rest[l] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // History of DUT outputs for the literal timing checks.
  int h_rom_en0[HMAX], h_addr0[HMAX], h_ten0[HMAX], h_div0[HMAX];
  int h_done0[HMAX], h_busy0[HMAX], h_idx0[HMAX];
  int h_rom_en1[HMAX], h_addr1[HMAX], h_busy1[HMAX];

  task automatic compare_lane(input int l, input logic rom_en, input logic [9:0] addr,
                              input logic [13:0] div, input logic ten,
                              input logic [9:0] idx, input logic busy, input logic done);
    int playing, exp_ten;
    playing = (m_run[l] != 0 && m_pause[l] == 0) ? 1 : 0;
    exp_ten = (playing != 0 && m_pos[l] >= 2 && m_rest[l] == 0 &&
               (m_len[l] - 1 - (m_pos[l] - 2)) >= GAP) ? 1 : 0;
    check($sformatf("L%0d_rom_en@%0d", l, cyc), 32'(rom_en),
          32'((playing != 0 && m_pos[l] == 0) ? 1 : 0));
    check($sformatf("L%0d_rom_addr@%0d", l, cyc), 32'(addr), 32'(m_idx[l]));
    check($sformatf("L%0d_note_idx@%0d", l, cyc), 32'(idx), 32'(m_idx[l]));
    check($sformatf("L%0d_tone_div@%0d", l, cyc), 32'(div), 32'(m_div[l]));
    check($sformatf("L%0d_tone_en@%0d", l, cyc), 32'(ten), 32'(exp_ten));
    check($sformatf("L%0d_busy@%0d", l, cyc), 32'(busy), 32'(m_run[l]));
    check($sformatf("L%0d_done@%0d", l, cyc), 32'(done), 32'(m_fin[l]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        compare_lane(0, bus0.rom_en, bus0.rom_addr, bus0.tone_div, bus0.tone_en,
                     bus0.note_idx, bus0.busy, bus0.done);
        compare_lane(1, bus1.rom_en, bus1.rom_addr, bus1.tone_div, bus1.tone_en,
                     bus1.note_idx, bus1.busy, bus1.done);
      end
      if (cyc < HMAX) begin
        h_rom_en0[cyc] = int'(bus0.rom_en);
        h_addr0[cyc]   = int'(bus0.rom_addr);
        h_ten0[cyc]    = int'(bus0.tone_en);
        h_div0[cyc]    = int'(bus0.tone_div);
        h_done0[cyc]   = int'(bus0.done);
        h_busy0[cyc]   = int'(bus0.busy);
        h_idx0[cyc]    = int'(bus0.note_idx);
        h_rom_en1[cyc] = int'(bus1.rom_en);
        h_addr1[cyc]   = int'(bus1.rom_addr);
        h_busy1[cyc]   = int'(bus1.busy);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  // which: 1 play, 2 pause, 3 next, 4 stop
  task automatic pulse(input int which);
    cmd_play  = (which == 1);
    cmd_pause = (which == 2);
    cmd_next  = (which == 3);
    cmd_stop  = (which == 4);
    tick();
    cmd_play = 1'b0; cmd_pause = 1'b0; cmd_next = 1'b0; cmd_stop = 1'b0;
  endtask

  initial begin
    int t0, t1, ts, t2, t3, t4, t5, k;
    rst = 1'b1;
    cmd_play = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0; cmd_next = 1'b0;
    tempo_sel = 2'b00;
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset_tone_div", 32'(h_div0[3]), 32'd0);
    check("reset_busy",     32'(h_busy0[3] + h_done0[3] + h_ten0[3] + h_rom_en0[3]), 32'd0);

    // Full song at x1 tempo: period 12 per note.
    go_to(5);
    t0 = cyc;
    pulse(1);
    go_to(t0 + 53);
    check("first_fetch",     32'(h_rom_en0[t0 + 1]), 32'd1);
    check("first_div",       32'(h_div0[t0 + 3]),    32'd10);
    check("tone_on_start",   32'(h_ten0[t0 + 3]),    32'd1);
    check("tone_on_end",     32'(h_ten0[t0 + 10]),   32'd1);
    check("gap_first",       32'(h_ten0[t0 + 11]),   32'd0);
    check("gap_second",      32'(h_ten0[t0 + 12]),   32'd0);
    check("second_fetch",    32'(h_rom_en0[t0 + 13]), 32'd1);
    check("second_addr",     32'(h_addr0[t0 + 13]),  32'd1);
    check("rest_div",        32'(h_div0[t0 + 27]),   32'd30);
    k = 0;
    for (int i = t0 + 27; i <= t0 + 36; i++) k += h_ten0[i];
    check("rest_silent",     32'(k), 32'd0);
    check("done_not_early",  32'(h_done0[t0 + 48]), 32'd0);
    check("done_set",        32'(h_done0[t0 + 49]), 32'd1);
    check("done_busy",       32'(h_busy0[t0 + 49]), 32'd0);
    check("done_idx",        32'(h_idx0[t0 + 49]),  32'd3);
    check("done_tone",       32'(h_ten0[t0 + 49]),  32'd0);
    check("loop_fetch",      32'(h_rom_en1[t0 + 49]), 32'd1);
    check("loop_addr",       32'(h_addr1[t0 + 49]),   32'd0);

    // Restart from DONE.
    t1 = cyc;
    pulse(1);
    go_to(t1 + 3);
    check("restart_fetch",   32'(h_rom_en0[t1 + 1]), 32'd1);
    check("restart_addr",    32'(h_addr0[t1 + 1]),   32'd0);

    ts = cyc;
    pulse(4);
    go_to(ts + 2);
    check("stop_busy0",      32'(h_busy0[ts + 1]), 32'd0);
    check("stop_busy1",      32'(h_busy1[ts + 1]), 32'd0);

    // Pause at beat_cnt=5 for 20 cycles, then resume.
    t2 = cyc;
    pulse(1);
    go_to(t2 + 7);
    pulse(2);
    go_to(t2 + 27);
    pulse(1);
    go_to(t2 + 36);
    check("pause_silent",    32'(h_ten0[t2 + 8]),  32'd0);
    check("pause_busy",      32'(h_busy0[t2 + 20]), 32'd1);
    k = 0;
    for (int i = t2 + 28; i <= t2 + 33; i++) k += h_ten0[i];
    check("resume_tone_cnt", 32'(k), 32'd4);
    check("resume_gap",      32'(h_ten0[t2 + 32]), 32'd0);
    check("resume_fetch",    32'(h_rom_en0[t2 + 34]), 32'd1);
    check("resume_addr",     32'(h_addr0[t2 + 34]),   32'd1);

    // Tempo x2 faster, then slower selected mid-note.
    pulse(4);
    tempo_sel = 2'b01;
    t3 = cyc;
    pulse(1);
    go_to(t3 + 10);
    tempo_sel = 2'b10;
    go_to(t3 + 40);
    check("fast_period",     32'(h_rom_en0[t3 + 8]),  32'd1);
    check("midnote_tempo",   32'(h_rom_en0[t3 + 15]), 32'd1);
    k = 0;
    for (int i = t3 + 16; i <= t3 + 36; i++) k += h_rom_en0[i];
    check("slow_len",        32'(k), 32'd0);
    check("slow_fetch",      32'(h_rom_en0[t3 + 37]), 32'd1);
    check("slow_addr",       32'(h_addr0[t3 + 37]),   32'd3);

    // stop + next together in PLAY.
    pulse(4);
    tempo_sel = 2'b00;
    t4 = cyc;
    pulse(1);
    go_to(t4 + 5);
    cmd_stop = 1'b1; cmd_next = 1'b1;
    tick();
    cmd_stop = 1'b0; cmd_next = 1'b0;
    go_to(t4 + 7);
    check("stopnext_busy",   32'(h_busy0[t4 + 6]), 32'd0);
    check("stopnext_idx",    32'(h_idx0[t4 + 6]),  32'd0);
    check("stop_keeps_div",  32'(h_div0[t4 + 6]),  32'd10);

    // next alone, then reset in the middle of the following note.
    t5 = cyc;
    pulse(1);
    go_to(t5 + 5);
    pulse(3);
    go_to(t5 + 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    go_to(t5 + 13);
    check("next_fetch",      32'(h_rom_en0[t5 + 6]), 32'd1);
    check("next_addr",       32'(h_addr0[t5 + 6]),   32'd1);
    check("pre_rst_div",     32'(h_div0[t5 + 10]),   32'd20);
    check("pre_rst_tone",    32'(h_ten0[t5 + 10]),   32'd1);
    check("rst_div",         32'(h_div0[t5 + 11]),   32'd0);
    check("rst_outputs",     32'(h_busy0[t5 + 11] + h_ten0[t5 + 11] +
                                 h_rom_en0[t5 + 11] + h_idx0[t5 + 11]), 32'd0);

    go_to(cyc + 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
